// File: rtl/mem_cmd_arbiter_pkg.sv
// Shared types for the memory command arbiter.
// Command layout matches the MIG adapter command FIFO.
package da_mem_pkg;

  localparam int MEM_CMD_WIDTH = 65;

  typedef struct packed {
    logic        is_read;
    logic [31:0] addr;
    logic [31:0] len;
  } mem_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WDATA
  } arb_state_t;

endpackage

// File: rtl/mem_cmd_arbiter_read_tag_fifo.sv
// In-order read tag FIFO: {slot, remaining beats} per read in flight.
// The head length is decremented in place as return beats arrive.
module read_tag_fifo #(
  parameter int depth = 8,
  parameter int sw    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [sw-1:0] push_slot,
  input  logic [31:0]   push_len,
  input  logic          pop,
  input  logic          dec,
  output logic          full,
  output logic          empty,
  output logic [sw-1:0] head_slot,
  output logic [31:0]   head_len
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  logic [sw-1:0] slot_mem [depth];
  logic [31:0]   len_mem  [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == (AW+1)'(depth));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_slot = slot_mem[rd_ptr];
  assign head_len  = len_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) begin
        slot_mem[i] <= '0;
        len_mem[i]  <= '0;
      end
    end else begin
      if (dec && !empty)
        len_mem[rd_ptr] <= len_mem[rd_ptr] - 32'd1;
      // a push into a slot freed this cycle overrides the decrement
      if (do_push) begin
        slot_mem[wr_ptr] <= push_slot;
        len_mem[wr_ptr]  <= push_len;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Round-robin arbiter of per-slot read/write bursts onto the
// single MIG command/write/read FIFO triple, with in-order read return.
module mem_cmd_arbiter
  import da_mem_pkg::*;
#(
  parameter int num_slots       = 4,
  parameter int mem_width       = 32,
  parameter int max_outstanding = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_slots*65-1:0]        req_data,
  input  logic [num_slots-1:0]           req_valid,
  output logic [num_slots-1:0]           req_ready,
  input  logic [num_slots*mem_width-1:0] wr_data,
  input  logic [num_slots-1:0]           wr_valid,
  output logic [num_slots-1:0]           wr_ready,
  output logic [mem_width-1:0]           rd_data,
  output logic [num_slots-1:0]           rd_valid,
  input  logic [num_slots-1:0]           rd_ready,
  output logic [MEM_CMD_WIDTH-1:0]       mem_cmd_data,
  output logic                           mem_cmd_valid,
  input  logic                           mem_cmd_ready,
  output logic [mem_width-1:0]           mem_write_data,
  output logic                           mem_write_valid,
  input  logic                           mem_write_ready,
  input  logic [mem_width-1:0]           mem_read_data,
  input  logic                           mem_read_valid,
  output logic                           mem_read_ready
);

  localparam int SW = (num_slots > 1) ? $clog2(num_slots) : 1;

  arb_state_t    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [SW-1:0] rr_q, rr_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic [31:0]   word_cnt_q, word_cnt_d;

  mem_cmd_t       reqs [num_slots];
  logic [num_slots-1:0] elig;
  logic           found;
  logic [SW-1:0]  gnt;

  logic          tag_push;
  logic          tag_pop;
  logic          tag_dec;
  logic          tag_full;
  logic          tag_empty;
  logic [SW-1:0] head_slot;
  logic [31:0]   head_len;

  read_tag_fifo #(
    .depth(max_outstanding),
    .sw   (SW)
  ) u_tags (
    .clk      (clk),
    .reset    (reset),
    .push     (tag_push),
    .push_slot(slot_q),
    .push_len (cmd_q.len),
    .pop      (tag_pop),
    .dec      (tag_dec),
    .full     (tag_full),
    .empty    (tag_empty),
    .head_slot(head_slot),
    .head_len (head_len)
  );

  always_comb begin
    for (int i = 0; i < num_slots; i++) begin
      reqs[i] = req_data[65*i +: 65];
      elig[i] = req_valid[i] && !(reqs[i].is_read && tag_full);
    end
  end

  always_comb begin : grant_blk
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < num_slots; k++) begin
      idx = (int'(rr_q) + k) % num_slots;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      rr_q       <= '0;
      cmd_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      rr_q       <= rr_d;
      cmd_q      <= cmd_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    rr_d            = rr_q;
    cmd_d           = cmd_q;
    word_cnt_d      = word_cnt_q;
    req_ready       = '0;
    wr_ready        = '0;
    tag_push        = 1'b0;
    mem_cmd_valid   = 1'b0;
    mem_cmd_data    = cmd_q;
    mem_write_valid = 1'b0;
    mem_write_data  = wr_data[slot_q*mem_width +: mem_width];
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[gnt] = 1'b1;
          rr_d = (int'(gnt) == num_slots - 1) ? '0 : gnt + 1'b1;
          // zero-length requests are consumed without a command
          if (reqs[gnt].len != 32'd0) begin
            slot_d  = gnt;
            cmd_d   = reqs[gnt];
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          if (cmd_q.is_read) begin
            tag_push = 1'b1;
            state_d  = IDLE;
          end else begin
            word_cnt_d = cmd_q.len;
            state_d    = WDATA;
          end
        end
      end
      WDATA: begin
        mem_write_valid  = wr_valid[slot_q];
        wr_ready[slot_q] = mem_write_ready;
        if (wr_valid[slot_q] && mem_write_ready) begin
          word_cnt_d = word_cnt_q - 32'd1;
          if (word_cnt_q == 32'd1)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data = mem_read_data;

  always_comb begin
    rd_valid       = '0;
    mem_read_ready = 1'b0;
    tag_pop        = 1'b0;
    tag_dec        = 1'b0;
    if (!tag_empty) begin
      rd_valid[head_slot] = mem_read_valid;
      mem_read_ready      = rd_ready[head_slot];
      if (mem_read_valid && rd_ready[head_slot]) begin
        if (head_len == 32'd1)
          tag_pop = 1'b1;
        else
          tag_dec = 1'b1;
      end
    end
  end

endmodule
